// File: rtl/sccb_master.sv
// SCCB/I2C register master: one write (id, reg, data) or read (id, reg | restart, id, data)
// per accepted command, with programmable quarter-bit timing and optional ACK checking.
module sccb_master #(
    parameter int unsigned CLK_DIV      = 63,
    parameter bit          ACK_CHECK    = 1'b0,
    parameter int unsigned GAP_QUARTERS = 4
) (
    input  logic       clk_cam_i2c,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_id,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned QTR_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [QTR_W-1:0] GAP_LAST = QTR_W'(GAP_QUARTERS - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BYTE  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Byte slots on the wire; a read restarts at B_ID_R after the first STOP/GAP
    localparam logic [2:0] B_ID_W  = 3'd0;
    localparam logic [2:0] B_REG   = 3'd1;
    localparam logic [2:0] B_WDATA = 3'd2;
    localparam logic [2:0] B_ID_R  = 3'd3;
    localparam logic [2:0] B_RDATA = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [QTR_W-1:0] qtr, qtr_nxt;
    logic [3:0]       bit_idx, bit_nxt;
    logic [2:0]       byte_idx, byte_nxt;
    logic             second, second_nxt;
    logic             nack, nack_nxt;
    logic             rw_q, rw_nxt;
    logic [6:0]       id_q, id_nxt;
    logic [7:0]       reg_q, reg_nxt;
    logic [7:0]       wdata_q, wdata_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       rsp_rdata_nxt;
    logic             rsp_nack_nxt;
    logic             scl_nxt, sda_oe_nxt;
    logic             quarter_end, last_byte;
    logic [7:0]       tx_byte;

    // Device address LSB is replaced by the phase direction
    logic unused_cmd_id0;
    assign unused_cmd_id0 = cmd_id[0];

    // Next-state, datapath and next-output logic
    always_comb begin
        state_nxt     = state;
        div_nxt       = div_cnt;
        qtr_nxt       = qtr;
        bit_nxt       = bit_idx;
        byte_nxt      = byte_idx;
        second_nxt    = second;
        nack_nxt      = nack;
        rw_nxt        = rw_q;
        id_nxt        = id_q;
        reg_nxt       = reg_q;
        wdata_nxt     = wdata_q;
        shreg_nxt     = shreg;
        rsp_rdata_nxt = rsp_rdata;
        rsp_nack_nxt  = rsp_nack;
        scl_nxt       = 1'b1;
        sda_oe_nxt    = 1'b0;
        tx_byte       = 8'hFF;
        quarter_end   = (div_cnt == DIV_LAST);
        last_byte     = (byte_idx == B_WDATA) || (byte_idx == B_RDATA) ||
                        (rw_q && (byte_idx == B_REG));

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt  = ST_START;
                    div_nxt    = '0;
                    qtr_nxt    = '0;
                    bit_nxt    = '0;
                    byte_nxt   = B_ID_W;
                    second_nxt = 1'b0;
                    nack_nxt   = 1'b0;
                    rw_nxt     = cmd_rw;
                    id_nxt     = cmd_id[7:1];
                    reg_nxt    = cmd_reg;
                    wdata_nxt  = cmd_wdata;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                div_nxt = quarter_end ? '0 : div_cnt + DIV_W'(1);
                if (quarter_end) begin
                    qtr_nxt = qtr + QTR_W'(1);
                    case (state)
                        ST_START: begin
                            if (qtr == QTR_W'(1)) begin
                                state_nxt = ST_BYTE;
                                qtr_nxt   = '0;
                                bit_nxt   = '0;
                            end
                        end
                        ST_BYTE: begin
                            // Data and ACK are both taken at the end of the first high quarter
                            if (qtr == QTR_W'(2)) begin
                                if (bit_idx != 4'd8) begin
                                    shreg_nxt = {shreg[6:0], sda_i};
                                end else if (ACK_CHECK && sda_i && (byte_idx != B_RDATA)) begin
                                    nack_nxt = 1'b1;
                                end
                            end
                            if (qtr == QTR_W'(3)) begin
                                qtr_nxt = '0;
                                if (bit_idx == 4'd8) begin
                                    bit_nxt = '0;
                                    if (nack || last_byte) begin
                                        state_nxt = ST_STOP;
                                    end else begin
                                        byte_nxt = byte_idx + 3'd1;
                                    end
                                end else begin
                                    bit_nxt = bit_idx + 4'd1;
                                end
                            end
                        end
                        ST_STOP: begin
                            if (qtr == QTR_W'(2)) begin
                                state_nxt = ST_GAP;
                                qtr_nxt   = '0;
                            end
                        end
                        ST_GAP: begin
                            if (qtr == GAP_LAST) begin
                                qtr_nxt = '0;
                                if (rw_q && !second && !nack) begin
                                    state_nxt  = ST_START;
                                    second_nxt = 1'b1;
                                    byte_nxt   = B_ID_R;
                                end else begin
                                    state_nxt    = ST_DONE;
                                    rsp_nack_nxt = nack;
                                    if (rw_q && !nack) begin
                                        rsp_rdata_nxt = shreg;
                                    end
                                end
                            end
                        end
                        default: begin
                            state_nxt = ST_IDLE;
                        end
                    endcase
                end
            end
        endcase

        case (byte_nxt)
            B_ID_W:  tx_byte = {id_nxt, 1'b0};
            B_REG:   tx_byte = reg_nxt;
            B_WDATA: tx_byte = wdata_nxt;
            B_ID_R:  tx_byte = {id_nxt, 1'b1};
            default: tx_byte = 8'hFF;
        endcase

        // Pad levels for the cycle the state register is about to enter
        case (state_nxt)
            ST_START: begin
                sda_oe_nxt = (qtr_nxt == QTR_W'(1));
            end
            ST_BYTE: begin
                scl_nxt = qtr_nxt[1];
                if ((bit_nxt != 4'd8) && (byte_nxt != B_RDATA)) begin
                    sda_oe_nxt = ~tx_byte[3'd7 - bit_nxt[2:0]];
                end
            end
            ST_STOP: begin
                scl_nxt    = (qtr_nxt != '0);
                sda_oe_nxt = (qtr_nxt != QTR_W'(2));
            end
            default: begin
                scl_nxt    = 1'b1;
                sda_oe_nxt = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk_cam_i2c or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            qtr       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            second    <= 1'b0;
            nack      <= 1'b0;
            rw_q      <= 1'b0;
            id_q      <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            shreg     <= '0;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            scl       <= 1'b1;
            sda_oe    <= 1'b0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            qtr       <= qtr_nxt;
            bit_idx   <= bit_nxt;
            byte_idx  <= byte_nxt;
            second    <= second_nxt;
            nack      <= nack_nxt;
            rw_q      <= rw_nxt;
            id_q      <= id_nxt;
            reg_q     <= reg_nxt;
            wdata_q   <= wdata_nxt;
            shreg     <= shreg_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_nack  <= rsp_nack_nxt;
            rsp_valid <= (state_nxt == ST_DONE);
            cmd_ready <= (state_nxt == ST_IDLE);
            busy      <= (state_nxt != ST_IDLE);
            scl       <= scl_nxt;
            sda_oe    <= sda_oe_nxt;
        end
    end

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master: bus decoder plus SCCB slave model on an ACK-checking
// instance, and a second instance without ACK checking against a slave that never answers.
module tb_sccb_master;

    localparam int EV_START = 'h1000;
    localparam int EV_STOP  = 'h2000;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid, cmd_valid2;
    logic       cmd_rw;
    logic [7:0] cmd_id, cmd_reg, cmd_wdata;

    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl, sda_oe, sda_i;
    logic [7:0] rsp_rdata;
    logic       cmd_ready2, rsp_valid2, rsp_nack2, busy2, scl2, sda_oe2, sda_i2;
    logic [7:0] rsp_rdata2;

    int checks = 0;
    int errors = 0;

    // Slave model configuration
    int         s_nack_byte = -1;
    logic [7:0] s_rdata     = 8'h00;

    // Monitor / slave state
    logic       p_scl, p_sda, active, seen_rise, rd_flag, s_pull;
    int         bitn, byten;
    logic [7:0] shreg;
    int         ev[$];
    logic       p_scl2;
    int         rise2 = 0;

    logic sda_bus;
    assign sda_bus = ~(sda_oe | s_pull);
    assign sda_i   = sda_bus;
    assign sda_i2  = ~sda_oe2;

    sccb_master #(.CLK_DIV(4), .ACK_CHECK(1'b1), .GAP_QUARTERS(4)) dut (
        .clk_cam_i2c(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_id(cmd_id), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_nack(rsp_nack),
        .busy(busy), .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    sccb_master #(.CLK_DIV(4), .ACK_CHECK(1'b0), .GAP_QUARTERS(4)) dut2 (
        .clk_cam_i2c(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_rw(cmd_rw),
        .cmd_id(cmd_id), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .rsp_nack(rsp_nack2),
        .busy(busy2), .scl(scl2), .sda_oe(sda_oe2), .sda_i(sda_i2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus decoder and slave: sees START/STOP, bytes (bit8 = ACK level), drives ACK and read data
    always @(negedge clk) begin : mon
        logic st, sp, rise, fall, nrd, pull;
        int   nb, nby;
        st   = p_scl && scl && p_sda && !sda_bus;
        sp   = p_scl && scl && !p_sda && sda_bus;
        rise = !p_scl && scl;
        fall = p_scl && !scl;
        if (!rst_n) begin
            p_scl <= 1'b1; p_sda <= 1'b1; active <= 1'b0; seen_rise <= 1'b0;
            s_pull <= 1'b0; bitn <= 0; byten <= 0; rd_flag <= 1'b0;
        end else begin
            p_scl <= scl;
            p_sda <= sda_bus;
            if (st) begin
                active <= 1'b1; seen_rise <= 1'b0; bitn <= 0; byten <= 0;
                rd_flag <= 1'b0; s_pull <= 1'b0;
                ev.push_back(EV_START);
            end else if (sp) begin
                active <= 1'b0; s_pull <= 1'b0;
                ev.push_back(EV_STOP);
            end else if (active && rise) begin
                seen_rise <= 1'b1;
                if (bitn < 8) shreg <= {shreg[6:0], sda_bus};
                else ev.push_back(sda_bus ? 256 + int'(shreg) : int'(shreg));
            end else if (active && fall) begin
                nb = bitn; nby = byten; nrd = rd_flag;
                if (seen_rise) begin
                    if (bitn == 8) begin nb = 0; nby = byten + 1; end
                    else nb = bitn + 1;
                end
                if (nby == 0 && nb == 8) nrd = shreg[0];
                pull = (nb == 8 && !(nrd && nby == 1) && nby < 3 && nby != s_nack_byte) ||
                       (nrd && nby == 1 && nb < 8 && !s_rdata[7-nb]);
                s_pull <= pull; bitn <= nb; byten <= nby; rd_flag <= nrd; seen_rise <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        p_scl2 <= scl2;
        if (!p_scl2 && scl2) rise2 <= rise2 + 1;
    end

    task automatic do_cmd(input logic rw, input logic [7:0] id, input logic [7:0] rg,
                          input logic [7:0] wd, output int lat, output logic [7:0] rd,
                          output logic nk, output logic pulse_low);
        int w;
        @(negedge clk);
        cmd_rw = rw; cmd_id = id; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
        rd = rsp_rdata;
        nk = rsp_nack;
        @(negedge clk);
        pulse_low = !rsp_valid;
    endtask

    task automatic do_cmd2(input logic [7:0] id, input logic [7:0] rg, input logic [7:0] wd,
                           output int lat, output logic nk);
        @(negedge clk);
        cmd_rw = 1'b0; cmd_id = id; cmd_reg = rg; cmd_wdata = wd; cmd_valid2 = 1'b1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        lat = 1;
        while (!rsp_valid2 && lat < 3000) begin @(negedge clk); lat++; end
        nk = rsp_nack2;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (scl !== 1'b1)       begin errors++; $display("FAIL rst_scl: got %b expected 1", scl); end
        checks++; if (sda_oe !== 1'b0)    begin errors++; $display("FAIL rst_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", cmd_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (rsp_nack !== 1'b0)  begin errors++; $display("FAIL rst_rsp_nack: got %b expected 0", rsp_nack); end
        checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %h expected 00", rsp_rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || scl !== 1'b1)
            begin errors++; $display("FAIL idle_after_rst: ready %b busy %b scl %b expected 1 0 1", cmd_ready, busy, scl); end
    endtask

    task automatic test_write;
        int base, lat;
        logic [7:0] rd;
        logic nk, pl;
        int exp[$];
        s_nack_byte = -1;
        base = ev.size();
        do_cmd(1'b0, 8'h42, 8'h12, 8'h46, lat, rd, nk, pl);
        checks++; if (lat !== 469) begin errors++; $display("FAIL wr_latency: got %0d expected 469", lat); end
        checks++; if (nk !== 1'b0) begin errors++; $display("FAIL wr_nack: got %b expected 0", nk); end
        checks++; if (pl !== 1'b1) begin errors++; $display("FAIL wr_pulse_width: rsp_valid still high next cycle"); end
        exp = '{EV_START, 'h042, 'h012, 'h046, EV_STOP};
        checks++; if (ev.size() - base !== exp.size())
            begin errors++; $display("FAIL wr_event_count: got %0d expected %0d", ev.size() - base, exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (base + i >= ev.size()) begin errors++; $display("FAIL wr_event[%0d]: missing expected %h", i, exp[i]); end
            else if (ev[base+i] !== exp[i]) begin errors++; $display("FAIL wr_event[%0d]: got %h expected %h", i, ev[base+i], exp[i]); end
        end
    endtask

    task automatic test_read;
        int base, lat;
        logic [7:0] rd;
        logic nk, pl;
        int exp[$];
        s_nack_byte = -1;
        s_rdata = 8'h77;
        base = ev.size();
        do_cmd(1'b1, 8'h43, 8'h0A, 8'h00, lat, rd, nk, pl);
        checks++; if (lat !== 649)  begin errors++; $display("FAIL rd_latency: got %0d expected 649", lat); end
        checks++; if (rd !== 8'h77) begin errors++; $display("FAIL rd_data: got %h expected 77", rd); end
        checks++; if (nk !== 1'b0)  begin errors++; $display("FAIL rd_nack: got %b expected 0", nk); end
        exp = '{EV_START, 'h042, 'h00A, EV_STOP, EV_START, 'h043, 'h177, EV_STOP};
        checks++; if (ev.size() - base !== exp.size())
            begin errors++; $display("FAIL rd_event_count: got %0d expected %0d", ev.size() - base, exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (base + i >= ev.size()) begin errors++; $display("FAIL rd_event[%0d]: missing expected %h", i, exp[i]); end
            else if (ev[base+i] !== exp[i]) begin errors++; $display("FAIL rd_event[%0d]: got %h expected %h", i, ev[base+i], exp[i]); end
        end
    endtask

    task automatic test_nack_abort;
        int base, lat;
        logic [7:0] rd;
        logic nk, pl;
        int exp[$];
        s_nack_byte = 1;
        s_rdata = 8'h99;
        base = ev.size();
        do_cmd(1'b1, 8'h43, 8'h0A, 8'h00, lat, rd, nk, pl);
        s_nack_byte = -1;
        checks++; if (lat !== 325)  begin errors++; $display("FAIL nack_latency: got %0d expected 325", lat); end
        checks++; if (nk !== 1'b1)  begin errors++; $display("FAIL nack_flag: got %b expected 1", nk); end
        checks++; if (rd !== 8'h77) begin errors++; $display("FAIL nack_rdata_hold: got %h expected 77", rd); end
        exp = '{EV_START, 'h042, 'h10A, EV_STOP};
        checks++; if (ev.size() - base !== exp.size())
            begin errors++; $display("FAIL nack_event_count: got %0d expected %0d", ev.size() - base, exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (base + i >= ev.size()) begin errors++; $display("FAIL nack_event[%0d]: missing expected %h", i, exp[i]); end
            else if (ev[base+i] !== exp[i]) begin errors++; $display("FAIL nack_event[%0d]: got %h expected %h", i, ev[base+i], exp[i]); end
        end
    endtask

    task automatic test_no_ack_ignored;
        int r0, lat;
        logic nk;
        r0 = rise2;
        do_cmd2(8'h42, 8'h12, 8'h46, lat, nk);
        checks++; if (lat !== 469)        begin errors++; $display("FAIL noack_latency: got %0d expected 469", lat); end
        checks++; if (nk !== 1'b0)        begin errors++; $display("FAIL noack_nack: got %b expected 0", nk); end
        checks++; if (rise2 - r0 !== 28)  begin errors++; $display("FAIL noack_scl_rises: got %0d expected 28", rise2 - r0); end
    endtask

    task automatic test_back_to_back;
        int base, lat, lat2, bad;
        int exp[$];
        s_nack_byte = -1;
        base = ev.size();
        @(negedge clk);
        cmd_rw = 1'b0; cmd_id = 8'h42; cmd_reg = 8'h12; cmd_wdata = 8'h46; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_reg = 8'h34; cmd_wdata = 8'h55;
        lat = 1; bad = 0;
        while (!rsp_valid && lat < 3000) begin
            if (cmd_ready) bad++;
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 469) begin errors++; $display("FAIL b2b_latency1: got %0d expected 469", lat); end
        checks++; if (bad !== 0)   begin errors++; $display("FAIL b2b_ready_while_busy: got %0d cycles expected 0", bad); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_rsp: got %b expected 1", cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL b2b_second_accept: ready %b busy %b expected 0 1", cmd_ready, busy); end
        cmd_valid = 1'b0;
        lat2 = 1;
        while (!rsp_valid && lat2 < 3000) begin @(negedge clk); lat2++; end
        checks++; if (lat2 !== 469) begin errors++; $display("FAIL b2b_latency2: got %0d expected 469", lat2); end
        checks++; if (rsp_nack !== 1'b0) begin errors++; $display("FAIL b2b_nack_cleared: got %b expected 0", rsp_nack); end
        @(negedge clk);
        exp = '{EV_START, 'h042, 'h012, 'h046, EV_STOP, EV_START, 'h042, 'h034, 'h055, EV_STOP};
        checks++; if (ev.size() - base !== exp.size())
            begin errors++; $display("FAIL b2b_event_count: got %0d expected %0d", ev.size() - base, exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (base + i >= ev.size()) begin errors++; $display("FAIL b2b_event[%0d]: missing expected %h", i, exp[i]); end
            else if (ev[base+i] !== exp[i]) begin errors++; $display("FAIL b2b_event[%0d]: got %h expected %h", i, ev[base+i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid_byte;
        int base, lat;
        logic [7:0] rd;
        logic nk, pl;
        int exp[$];
        @(negedge clk);
        cmd_rw = 1'b0; cmd_id = 8'h42; cmd_reg = 8'h12; cmd_wdata = 8'h46; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1 || scl !== 1'b0 || sda_oe !== 1'b1)
            begin errors++; $display("FAIL mid_byte_state: busy %b scl %b sda_oe %b expected 1 0 1", busy, scl, sda_oe); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (scl !== 1'b1)       begin errors++; $display("FAIL async_rst_scl: got %b expected 1", scl); end
        checks++; if (sda_oe !== 1'b0)    begin errors++; $display("FAIL async_rst_sda_oe: got %b expected 0", sda_oe); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL async_rst_ready: got %b expected 1", cmd_ready); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        base = ev.size();
        do_cmd(1'b0, 8'h42, 8'h12, 8'h46, lat, rd, nk, pl);
        checks++; if (lat !== 469) begin errors++; $display("FAIL post_rst_latency: got %0d expected 469", lat); end
        checks++; if (nk !== 1'b0) begin errors++; $display("FAIL post_rst_nack: got %b expected 0", nk); end
        exp = '{EV_START, 'h042, 'h012, 'h046, EV_STOP};
        checks++; if (ev.size() - base !== exp.size())
            begin errors++; $display("FAIL post_rst_event_count: got %0d expected %0d", ev.size() - base, exp.size()); end
        foreach (exp[i]) begin
            checks++;
            if (base + i >= ev.size()) begin errors++; $display("FAIL post_rst_event[%0d]: missing expected %h", i, exp[i]); end
            else if (ev[base+i] !== exp[i]) begin errors++; $display("FAIL post_rst_event[%0d]: got %h expected %h", i, ev[base+i], exp[i]); end
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_valid2 = 1'b0;
        cmd_rw     = 1'b0;
        cmd_id     = 8'h00;
        cmd_reg    = 8'h00;
        cmd_wdata  = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_nack_abort();
        test_no_ack_ignored();
        test_back_to_back();
        test_reset_mid_byte();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_master.md
Name: sccb_master

Overview:
Parametrised single-clock SCCB/I2C master, successor to the fixed write-only camera I2C shifter. Executes one register transaction per command: either a 3-phase write (id, reg, data) or a 2-phase-write + 2-phase-read register read. It has a programmable bit rate, optional ACK checking and a valid/ready command/response handshake. It sits between the camera register sequencer and the camera SIO_C/SIO_D pads.

Parameters:
CLK_DIV, 63, CLK cycles per quarter SCL period; legal range 1..1023; bit time = 4*CLK_DIV cycles.
ACK_CHECK, 0, 1: a slave NACK on any master-written byte aborts the transaction; 0: ACK bit ignored (SCCB "don't care").
GAP_QUARTERS, 4, bus-idle quarters between STOP and repeated START in a read, and after every STOP before the next command.

Ports:
CLK  in  1  system clock (25 MHz camera I2C domain)
RST_X  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept a command
cmd_rw  in  1  0 = write, 1 = read
cmd_id  in  8  device address; bit0 ignored (forced 0 for write phases, 1 for read phase)
cmd_reg  in  8  register address
cmd_wdata  in  8  write data; ignored on reads
rsp_valid  out  1  one-cycle pulse: transaction finished
rsp_rdata  out  8  read byte; valid with rsp_valid when rw=1
rsp_nack  out  1  valid with rsp_valid: 1 = aborted on NACK
busy  out  1  transaction in progress
scl  out  1  SIO_C, push-pull
sda_oe  out  1  1 = pull SIO_D low; 0 = release (pad pull-up)
sda_i  in  1  SIO_D pad input, already synchronised externally

Behaviour:
- Reset (async, RST_X=0): state IDLE, scl=1, sda_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_nack=0, rsp_rdata=0, all counters 0. Reset mid-transaction abandons the bus immediately; no STOP is generated.
- Handshake: accept on the cycle where cmd_valid & cmd_ready. All cmd_* fields are latched then. On the next cycle cmd_ready=0 and busy=1. cmd_ready returns to 1 the cycle after the rsp_valid pulse. cmd_valid while not ready is ignored.
- Quarter timer: counts 0..CLK_DIV-1. Every state change and bit phase advances on terminal count.
- START (2 quarters): Q0 scl=1, sda released. Q1 scl=1, sda_oe=1. Then go to BYTE with scl=0.
- BYTE, 9 bits MSB first, 4 quarters per bit:
  - Q0/Q1: scl=0, with SDA updated at the start of Q0.
  - Q2/Q3: scl=1.
  - Bit 9 (ACK) is released by the master on writes. On reads it is driven as the master NACK (released).
  - Data bits of a read byte are released; sda_i is sampled on the last cycle of Q2 into the shift register.
  - The ACK is sampled on the same edge.
- STOP (3 quarters): scl=0/sda_oe=1, then scl=1/sda_oe=1, then scl=1/sda_oe=0.
- GAP: scl=1, sda released, for GAP_QUARTERS quarters.
- Write sequence: START, {id[7:1],0}, reg, wdata, STOP, GAP, DONE.
- Read sequence: START, {id[7:1],0}, reg, STOP, GAP, START, {id[7:1],1}, read byte, STOP, GAP, DONE.
- NACK (ACK_CHECK=1, sampled sda_i=1 on a master-written byte): skip the remaining bytes, go to STOP, GAP, DONE with rsp_nack=1. rsp_rdata is unchanged on an aborted read.
- DONE: rsp_valid=1 for exactly one cycle, then IDLE.
  - rsp_rdata updates only on successful reads and holds its value otherwise.
  - rsp_nack holds until the next rsp_valid.
- Latency, CLK_DIV=D, G=GAP_QUARTERS, counted from the accept cycle to rsp_valid:
  - Write: (2+27*4+3+G)*D+1 cycles; with G=4 this is 117*D+1.
  - Read: (2+18*4+3+G+2+18*4+3+G)*D+1 cycles; with G=4 this is 162*D+1.
- sda_oe changes only while scl=0, except in START and STOP.

Test Plan:
- Write, CLK_DIV=4, id=0x42, reg=0x12, wdata=0x46 with a slave model ACKing -> bus decodes 0x42,0x12,0x46 with valid START/STOP; rsp_valid exactly 469 cycles after accept; rsp_nack=0.
- Read, id=0x43 (bit0 forced), reg=0x0A, slave returns 0x77 -> bus shows 0x42,0x0A,STOP,START,0x43, master NACK; rsp_rdata=0x77 with rsp_valid after 649 cycles.
- ACK_CHECK=1, slave NACKs the reg byte -> no data byte on the bus; STOP follows the ACK slot; rsp_nack=1; rsp_rdata unchanged.
- ACK_CHECK=0, slave never ACKs -> full write sequence completes; rsp_nack=0.
- cmd_valid held high continuously across two commands -> second accepted exactly one cycle after the first rsp_valid; cmd_ready=0 throughout busy.
- RST_X low mid-byte -> scl=1, sda_oe=0, cmd_ready=1 immediately (asynchronous); next command after release completes normally.
